// File: rtl/aes_ctrl_pkg.sv
// Shared types and widths for the AES request arbiter.
package aes_ctrl_pkg;

    localparam int AES_BLK_W = 128;
    localparam int REQ_ID_W  = 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        RESP,
        GAP
    } state_e;

endpackage

// File: rtl/aes_rr_arb2.sv
// Two-way round-robin grant: on a tie the requester that did not win last
// time is chosen; a lone requester is always chosen.
module aes_rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic [1:0] gnt_o,
    output logic       gnt_id_o
);

    always_comb begin
        gnt_id_o = 1'b0;
        unique case (req_i)
            2'b11:   gnt_id_o = ~last_grant_i;
            2'b10:   gnt_id_o = 1'b1;
            default: gnt_id_o = 1'b0;
        endcase
        gnt_o = {gnt_id_o, ~gnt_id_o} & {2{|req_i}};
    end

endmodule

// File: rtl/aes_req_arbiter.sv
// Shares one AES_top core between two requesters, one job at a time.
// Define AES_ARB_TIMEOUT_EN to abort jobs that stay in RUN too long.
module aes_req_arbiter
    import aes_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 AES_clk,
    input  logic                 AES_rst,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [AES_BLK_W-1:0] req0_data,
    input  logic [AES_BLK_W-1:0] req0_key,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [AES_BLK_W-1:0] req1_data,
    input  logic [AES_BLK_W-1:0] req1_key,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [REQ_ID_W-1:0]  rsp_id,
    output logic [AES_BLK_W-1:0] rsp_data,
    output logic                 rsp_err,
    output logic                 core_en,
    output logic [AES_BLK_W-1:0] core_data_in,
    output logic [AES_BLK_W-1:0] core_key_in,
    input  logic [AES_BLK_W-1:0] core_data_out,
    input  logic                 core_data_out_valid,
    output logic                 busy
);

    state_e                state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic [AES_BLK_W-1:0]  job_data_q, job_data_d;
    logic [AES_BLK_W-1:0]  job_key_q, job_key_d;
    logic [REQ_ID_W-1:0]   job_id_q, job_id_d;
    logic [AES_BLK_W-1:0]  rsp_data_q, rsp_data_d;
    logic                  rsp_err_q, rsp_err_d;

    logic [1:0] req_v;
    logic [1:0] gnt;
    logic       gnt_id;

    assign req_v = {req1_valid, req0_valid};

    aes_rr_arb2 u_arb (
        .req_i        (req_v),
        .last_grant_i (last_grant_q),
        .gnt_o        (gnt),
        .gnt_id_o     (gnt_id)
    );

`ifdef AES_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tmo;

    // cnt_q is the number of RUN cycles already completed
    assign tmo = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        job_data_d   = job_data_q;
        job_key_d    = job_key_q;
        job_id_d     = job_id_q;
        rsp_data_d   = rsp_data_q;
        rsp_err_d    = rsp_err_q;
`ifdef AES_ARB_TIMEOUT_EN
        cnt_d        = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (|req_v) begin
                    state_d      = RUN;
                    last_grant_d = gnt_id;
                    job_id_d     = gnt_id;
                    job_data_d   = gnt_id ? req1_data : req0_data;
                    job_key_d    = gnt_id ? req1_key : req0_key;
`ifdef AES_ARB_TIMEOUT_EN
                    cnt_d        = '0;
`endif
                end
            end
            RUN: begin
                if (core_data_out_valid) begin
                    state_d    = RESP;
                    rsp_data_d = core_data_out;
                    rsp_err_d  = 1'b0;
                end
`ifdef AES_ARB_TIMEOUT_EN
                else if (tmo) begin
                    state_d    = RESP;
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = GAP;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge AES_clk or posedge AES_rst) begin
        if (AES_rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            job_data_q   <= '0;
            job_key_q    <= '0;
            job_id_q     <= '0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
`ifdef AES_ARB_TIMEOUT_EN
            cnt_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            job_data_q   <= job_data_d;
            job_key_q    <= job_key_d;
            job_id_q     <= job_id_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
`ifdef AES_ARB_TIMEOUT_EN
            cnt_q        <= cnt_d;
`endif
        end
    end

    assign req0_ready   = (state_q == IDLE) && gnt[0] && !AES_rst;
    assign req1_ready   = (state_q == IDLE) && gnt[1] && !AES_rst;
    assign core_en      = (state_q == RUN);
    assign core_data_in = job_data_q;
    assign core_key_in  = job_key_q;
    assign rsp_valid    = (state_q == RESP);
    assign rsp_id       = job_id_q;
    assign rsp_data     = rsp_data_q;
    assign busy         = (state_q != IDLE);

`ifdef AES_ARB_TIMEOUT_EN
    assign rsp_err = rsp_err_q;
`else
    logic unused_err;
    assign unused_err = rsp_err_q;
    assign rsp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_aes_req_arbiter.sv
// Directed bench for aes_req_arbiter; the AES core is a stub that answers
// with FIPS-197 known-answer ciphertexts after a programmable latency.
module tb_aes_req_arbiter;

`ifdef AES_ARB_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 255;
`endif

    localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_A  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_A  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] JUNK  = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;

    logic         AES_clk = 1'b0;
    logic         AES_rst = 1'b1;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready, req1_ready;
    logic [127:0] req0_data = PT_A, req0_key = KEY_A;
    logic [127:0] req1_data = PT_B, req1_key = KEY_B;
    logic         rsp_valid, rsp_err;
    logic         rsp_ready = 1'b1;
    logic [0:0]   rsp_id;
    logic [127:0] rsp_data;
    logic         core_en;
    logic [127:0] core_data_in, core_key_in;
    logic [127:0] core_data_out;
    logic         core_data_out_valid;
    logic         busy;

    int tests = 0;
    int fails = 0;

    int           stub_lat = 4;
    int           stub_cnt = 0;
    logic         stub_v = 1'b0;
    logic [127:0] stub_d = '0;
    logic         spur = 1'b0;

    always #5 AES_clk = ~AES_clk;

    aes_req_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .AES_clk             (AES_clk),
        .AES_rst             (AES_rst),
        .req0_valid          (req0_valid),
        .req0_ready          (req0_ready),
        .req0_data           (req0_data),
        .req0_key            (req0_key),
        .req1_valid          (req1_valid),
        .req1_ready          (req1_ready),
        .req1_data           (req1_data),
        .req1_key            (req1_key),
        .rsp_valid           (rsp_valid),
        .rsp_ready           (rsp_ready),
        .rsp_id              (rsp_id),
        .rsp_data            (rsp_data),
        .rsp_err             (rsp_err),
        .core_en             (core_en),
        .core_data_in        (core_data_in),
        .core_key_in         (core_key_in),
        .core_data_out       (core_data_out),
        .core_data_out_valid (core_data_out_valid),
        .busy                (busy)
    );

    function automatic logic [127:0] kat(input logic [127:0] k,
                                         input logic [127:0] p);
        if (k == KEY_A && p == PT_A) return CT_A;
        if (k == KEY_B && p == PT_B) return CT_B;
        return JUNK;
    endfunction

    // Stub core: valid pulses once after stub_lat cycles of core_en
    always @(negedge AES_clk) begin
        if (core_en) begin
            stub_cnt = stub_cnt + 1;
            stub_v   = (stub_cnt == stub_lat);
            stub_d   = kat(core_key_in, core_data_in);
        end else begin
            stub_cnt = 0;
            stub_v   = 1'b0;
        end
    end

    assign core_data_out_valid = stub_v | spur;
    assign core_data_out       = spur ? JUNK : stub_d;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Present requests at an IDLE negedge; ends at the first RUN negedge
    task automatic issue(input logic v0, input logic v1, input logic id);
        req0_valid = v0;
        req1_valid = v1;
        #1;
        chk("req0_ready_grant", req0_ready, !id);
        chk("req1_ready_grant", req1_ready, id);
        @(negedge AES_clk);
        if (id) req1_valid = 1'b0;
        else    req0_valid = 1'b0;
        chk("core_en_T1", core_en, 1'b1);
        chk("busy_T1", busy, 1'b1);
        chk("core_data_in", core_data_in, id ? PT_B : PT_A);
        chk("core_key_in", core_key_in, id ? KEY_B : KEY_A);
        chk("ready_in_run", {req1_ready, req0_ready}, 2'b00);
    endtask

    task automatic run_to_rsp(input logic id);
        for (int i = 2; i <= 4; i++) begin
            @(negedge AES_clk);
            chk("core_en_run", core_en, 1'b1);
            chk("rsp_valid_run", rsp_valid, 1'b0);
        end
        @(negedge AES_clk);
        chk("rsp_valid", rsp_valid, 1'b1);
        chk("core_en_resp", core_en, 1'b0);
        chk("rsp_id", rsp_id, id);
        chk("rsp_data", rsp_data, id ? CT_B : CT_A);
        chk("rsp_err", rsp_err, 1'b0);
    endtask

    task automatic finish_job(input logic id);
        run_to_rsp(id);
        @(negedge AES_clk);
        chk("gap_busy", busy, 1'b1);
        chk("gap_rsp_valid", rsp_valid, 1'b0);
        chk("gap_core_en", core_en, 1'b0);
        @(negedge AES_clk);
        chk("idle_busy", busy, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge AES_clk);
        AES_rst = 1'b1;
        @(negedge AES_clk);
        AES_rst = 1'b0;
    endtask

    initial begin
        logic ok;

        repeat (3) @(negedge AES_clk);
        chk("rst_core_en", core_en, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", {req1_ready, req0_ready}, 2'b00);
        chk("rst_rsp_data", rsp_data, '0);
        chk("rst_rsp_id", rsp_id, 1'b0);
        chk("rst_rsp_err", rsp_err, 1'b0);
        chk("rst_core_data", core_data_in, '0);
        chk("rst_core_key", core_key_in, '0);
        AES_rst = 1'b0;
        @(negedge AES_clk);

        issue(1'b1, 1'b0, 1'b0);
        finish_job(1'b0);

        do_reset();
        for (int j = 0; j < 4; j++) begin
            issue(1'b1, 1'b1, j[0]);
            finish_job(j[0]);
        end

        rsp_ready = 1'b0;
        issue(1'b1, 1'b0, 1'b0);
        run_to_rsp(1'b0);
        req1_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge AES_clk);
            chk("bp_rsp_valid", rsp_valid, 1'b1);
            chk("bp_rsp_data", rsp_data, CT_A);
            chk("bp_rsp_id", rsp_id, 1'b0);
            chk("bp_core_en", core_en, 1'b0);
            chk("bp_ready", {req1_ready, req0_ready}, 2'b00);
        end
        rsp_ready = 1'b1;
        @(negedge AES_clk);
        chk("rel_gap_valid", rsp_valid, 1'b0);
        chk("rel_gap_busy", busy, 1'b1);
        chk("rel_gap_ready", req1_ready, 1'b0);
        @(negedge AES_clk);
        chk("rel_accept", req1_ready, 1'b1);
        issue(1'b0, 1'b1, 1'b1);
        finish_job(1'b1);

        spur = 1'b1;
        @(negedge AES_clk);
        spur = 1'b0;
        chk("spur_rsp_valid", rsp_valid, 1'b0);
        chk("spur_busy", busy, 1'b0);
        chk("spur_core_en", core_en, 1'b0);
        @(negedge AES_clk);
        chk("spur_rsp_valid2", rsp_valid, 1'b0);
        chk("spur_busy2", busy, 1'b0);

        stub_lat = 1000;
        issue(1'b1, 1'b0, 1'b0);
        repeat (4) @(negedge AES_clk);
        chk("mid_core_en", core_en, 1'b1);
        AES_rst = 1'b1;
        #1;
        chk("mid_rst_core_en", core_en, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        @(negedge AES_clk);
        AES_rst = 1'b0;
        ok = 1'b1;
        repeat (3) begin
            @(negedge AES_clk);
            if (rsp_valid !== 1'b0 || busy !== 1'b0) ok = 1'b0;
        end
        chk("mid_no_rsp", ok, 1'b1);
        stub_lat = 4;
        issue(1'b1, 1'b1, 1'b0);
        finish_job(1'b0);

        stub_lat = 1000000;
        issue(1'b1, 1'b0, 1'b0);
`ifdef AES_ARB_TIMEOUT_EN
        ok = 1'b1;
        for (int k = 2; k <= 16; k++) begin
            @(negedge AES_clk);
            if (rsp_valid !== 1'b0) ok = 1'b0;
        end
        chk("tmo_early", ok, 1'b1);
        @(negedge AES_clk);
        chk("tmo_rsp_valid", rsp_valid, 1'b1);
        chk("tmo_rsp_err", rsp_err, 1'b1);
        chk("tmo_rsp_data", rsp_data, '0);
        chk("tmo_rsp_id", rsp_id, 1'b0);
        chk("tmo_core_en", core_en, 1'b0);
        @(negedge AES_clk);
        chk("tmo_gap_busy", busy, 1'b1);
        @(negedge AES_clk);
        chk("tmo_idle_busy", busy, 1'b0);
`else
        ok = 1'b1;
        repeat (1000) begin
            @(negedge AES_clk);
            if (busy !== 1'b1 || rsp_valid !== 1'b0) ok = 1'b0;
        end
        chk("hang_busy", ok, 1'b1);
        do_reset();
        chk("hang_rst_busy", busy, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
